additive_engine: RTL and testbench
==================================

ADDITIVE_ENGINE -- requirements
Module: additive_engine

Interface
REQ-001 The block SHALL have parameter NUM_HARMONICS, default 16, meaning the number of harmonic slots (1..255).
REQ-002 The block SHALL have parameter PHASE_MOD, default 48000, meaning the phase wrap modulus, equal to the sample rate.
REQ-003 The block SHALL have parameter SAMPLE_INTERVAL, default 1500, meaning clocks per output sample.
REQ-004 The block SHALL have parameter LUT_SHIFT, default 5, meaning the right shift from phase to LUT address.
REQ-005 The block SHALL have parameter AMP_W, default 7, meaning amplitude fraction bits.
REQ-006 The block SHALL have parameter ACC_W, default 32, meaning accumulator width.
REQ-007 Port list (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frequency  in  16  fundamental frequency in Hz
- active_harmonics  in  8  number of harmonics to sum; 0 = silence
- amp_start  in  AMP_W  amplitude of the fundamental
- amp_step  in  AMP_W  amplitude decrement per harmonic
- lut_addr  out  11  sine LUT address
- lut_value  in  16  signed sine LUT data, valid 2 clocks after lut_addr
- sample_out  out  16  offset-binary output sample
- sample_valid  out  1  one-clock strobe, sample_out updated
- overrun  out  1  sticky flag: frame not finished in time
- clear_overrun  in  1  synchronous clear of overrun

Function
REQ-008 A free-running sample_timer SHALL count 0..SAMPLE_INTERVAL-1 and wrap, giving exactly one tick per SAMPLE_INTERVAL clocks.
REQ-009 The FSM SHALL have states CLEAR, IDLE, INIT, READ, CALC, ADDR, WAIT1, WAIT2, MAC, DONE.
REQ-010 Transitions SHALL be: CLEAR->IDLE after NUM_HARMONICS writes; IDLE->INIT on tick; INIT->READ; READ->CALC->ADDR->WAIT1->WAIT2->MAC; MAC->READ if more harmonics remain, else DONE; DONE->IDLE.
REQ-011 INIT SHALL latch frequency, active_harmonics clamped to NUM_HARMONICS, amp_start and amp_step; it SHALL also clear the accumulator, set h=1 and set increment=frequency, so mid-frame input changes have no effect.
REQ-012 For harmonic h, CALC SHALL compute phase_next = (phase[h] + increment) mod PHASE_MOD, where increment = h*frequency; this is built by repeated addition in a 24-bit register and reduced with a full modulo, so increment >= PHASE_MOD wraps correctly.
REQ-013 ADDR SHALL drive lut_addr = phase_next >> LUT_SHIFT and write phase_next to phase[h].
REQ-014 MAC SHALL add (lut_value * amp_h) >>> AMP_W, sign-extended, into the ACC_W accumulator, where amp_h = max(0, amp_start - (h-1)*amp_step).
REQ-015 Anti-alias rule: if increment >= PHASE_MOD/2, amp_h SHALL be 0 while the phase still advances.
REQ-016 Each harmonic SHALL take exactly 6 clocks, READ..MAC inclusive.
REQ-017 DONE SHALL saturate the accumulator to signed 16-bit, add 0x8000, register the result into sample_out and pulse sample_valid for 1 clock.
REQ-018 With active_harmonics=0, the FSM SHALL go INIT->DONE with an accumulator of 0, giving sample_out=0x8000.
REQ-019 If a tick occurs while the FSM is not in IDLE, overrun SHALL set, the tick SHALL be ignored and the current frame SHALL complete.
REQ-020 If clear_overrun and an overrun event occur on the same clock, set SHALL win.
REQ-021 Latency from tick to sample_valid SHALL be 3 + 6*active_harmonics clocks.

Reset
REQ-022 Reset SHALL set sample_out=0x8000, sample_valid=0, overrun=0, lut_addr=0, sample_timer=0, h=0 and FSM=CLEAR.
REQ-023 After reset deasserts, CLEAR SHALL write 0 to every phase entry, one per clock.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no sample_valid pulse, and the next frame SHALL start from zeroed phases.

Structure
REQ-025 Shared package additive_pkg SHALL hold the FSM state encoding, LUT_LATENCY=2 and the DAC offset constant 0x8000.
REQ-026 Phase storage SHALL be a sub-module phase_ram: synchronous, NUM_HARMONICS x 16, 1-clock read, write-first.
REQ-027 An elaboration check SHALL fail if SAMPLE_INTERVAL <= 3 + 6*NUM_HARMONICS.

Verification
REQ-028 Settings frequency=1000, active_harmonics=1, amp_start=127, amp_step=0, with an ideal sine LUT model -> consecutive lut_addr values step by 1000>>5 pairs (phase +1000 per sample), and sample_out tracks the model within 1 LSB.
REQ-029 Settings frequency=6000, active_harmonics=8 -> harmonics 4..8 have increment >= 24000 and contribute 0, while their phases still advance.
REQ-030 Settings active_harmonics=0 -> sample_out=0x8000 every SAMPLE_INTERVAL clocks, with latency 3.
REQ-031 Bench with SAMPLE_INTERVAL=100, NUM_HARMONICS=16, active=16, where a frame needs 99 clocks plus IDLE entry -> no overrun. Forcing a tick early via the timer preload -> overrun=1 stays high until clear_overrun.
REQ-032 Settings amp_start=10, amp_step=4, h=4 -> amp_h clamps at 0, with no negative contribution.
REQ-033 Reset pulsed mid-frame -> no sample_valid pulse, CLEAR runs 16 clocks, and the first post-reset frame matches a frame started from zero phases.

Source files
------------

// File: rtl/additive_pkg.sv
// Shared definitions for the additive synthesis engine: FSM encoding and fixed constants.
package additive_pkg;

    typedef enum logic [3:0] {
        StClear,
        StIdle,
        StInit,
        StRead,
        StCalc,
        StAddr,
        StWait1,
        StWait2,
        StMac,
        StDone
    } state_e;

    localparam int unsigned LUT_LATENCY = 2;
    localparam logic [15:0] DAC_OFFSET  = 16'h8000;

endpackage

// File: rtl/phase_ram.sv
// Per-harmonic phase store: single port, registered read, write-first.
module phase_ram #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clock,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       write_data,
    output logic [15:0]       read_data
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[addr] <= write_data;
            read_data <= write_data;
        end else begin
            read_data <= mem[addr];
        end
    end

endmodule

// File: rtl/additive_engine.sv
// Additive sine synthesiser: sums up to NUM_HARMONICS weighted harmonics per sample tick
// through an external sine LUT and emits an offset-binary sample.
module additive_engine
    import additive_pkg::*;
#(
    parameter int unsigned NUM_HARMONICS   = 16,
    parameter int unsigned PHASE_MOD       = 48000,
    parameter int unsigned SAMPLE_INTERVAL = 1500,
    parameter int unsigned LUT_SHIFT       = 5,
    parameter int unsigned AMP_W           = 7,
    parameter int unsigned ACC_W           = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [15:0]        frequency,
    input  logic [7:0]         active_harmonics,
    input  logic [AMP_W-1:0]   amp_start,
    input  logic [AMP_W-1:0]   amp_step,
    output logic [10:0]        lut_addr,
    input  logic signed [15:0] lut_value,
    output logic [15:0]        sample_out,
    output logic               sample_valid,
    output logic               overrun,
    input  logic               clear_overrun
);

    localparam int unsigned ADDR_W  = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
    localparam int unsigned TIMER_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
    localparam logic [24:0] MOD25    = 25'(PHASE_MOD);
    localparam logic [23:0] HALF_MOD = 24'(PHASE_MOD / 2);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    if (SAMPLE_INTERVAL <= 3 + 6 * NUM_HARMONICS) begin : g_interval_check
        $error("SAMPLE_INTERVAL too short for a full frame of NUM_HARMONICS");
    end
    // The WAIT1/WAIT2 pair below is sized for exactly this LUT latency.
    if (LUT_LATENCY != 2) begin : g_latency_check
        $error("FSM wait states assume a two-clock LUT");
    end

    state_e                   state;
    logic [TIMER_W-1:0]       sample_timer;
    logic                     tick;
    logic [15:0]              freq_l;
    logic [7:0]               active_l;
    logic [AMP_W-1:0]         amp_cur;
    logic [AMP_W-1:0]         amp_step_l;
    logic [23:0]              increment;
    logic [7:0]               h;
    logic [15:0]              phase_next;
    logic signed [ACC_W-1:0]  acc;

    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_addr;
    logic [15:0]              ram_wdata;
    logic [15:0]              ram_rdata;

    logic [24:0]              phase_sum;
    logic [AMP_W-1:0]         amp_eff;
    logic signed [AMP_W+16:0] product;
    logic signed [ACC_W-1:0]  term;
    logic [15:0]              sat16;

    assign tick = (sample_timer == TIMER_W'(SAMPLE_INTERVAL - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_timer <= '0;
        end else if (tick) begin
            sample_timer <= '0;
        end else begin
            sample_timer <= sample_timer + TIMER_W'(1);
        end
    end

    always_comb begin
        ram_we    = (state == StClear) || (state == StAddr);
        ram_addr  = (state == StClear) ? h[ADDR_W-1:0] : h[ADDR_W-1:0] - ADDR_W'(1);
        ram_wdata = (state == StClear) ? 16'h0000 : phase_next;
    end

    phase_ram #(
        .DEPTH (NUM_HARMONICS),
        .ADDR_W(ADDR_W)
    ) u_phase_ram (
        .clock       (clock),
        .write_enable(ram_we),
        .addr        (ram_addr),
        .write_data  (ram_wdata),
        .read_data   (ram_rdata)
    );

    always_comb begin
        phase_sum = {9'b0, ram_rdata} + {1'b0, increment};
        // Harmonics at or above Nyquist keep advancing phase but are muted.
        amp_eff   = (increment >= HALF_MOD) ? '0 : amp_cur;
        product   = $signed(lut_value) * $signed({1'b0, amp_eff});
        term      = ACC_W'(product >>> AMP_W);
        if (acc > SAT_MAX) begin
            sat16 = 16'h7fff;
        end else if (acc < SAT_MIN) begin
            sat16 = 16'h8000;
        end else begin
            sat16 = acc[15:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= StClear;
            h            <= '0;
            sample_out   <= DAC_OFFSET;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            lut_addr     <= '0;
            freq_l       <= '0;
            active_l     <= '0;
            amp_cur      <= '0;
            amp_step_l   <= '0;
            increment    <= '0;
            phase_next   <= '0;
            acc          <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (tick && state != StIdle) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
            unique case (state)
                StClear: begin
                    if (h == 8'(NUM_HARMONICS - 1)) begin
                        h     <= '0;
                        state <= StIdle;
                    end else begin
                        h <= h + 8'd1;
                    end
                end
                StIdle: if (tick) state <= StInit;
                StInit: begin
                    freq_l     <= frequency;
                    active_l   <= (active_harmonics > 8'(NUM_HARMONICS)) ?
                                  8'(NUM_HARMONICS) : active_harmonics;
                    amp_cur    <= amp_start;
                    amp_step_l <= amp_step;
                    increment  <= 24'(frequency);
                    acc        <= '0;
                    h          <= 8'd1;
                    state      <= (active_harmonics == 8'd0) ? StDone : StRead;
                end
                StRead: state <= StCalc;
                StCalc: begin
                    phase_next <= 16'(phase_sum % MOD25);
                    state      <= StAddr;
                end
                StAddr: begin
                    lut_addr <= 11'(phase_next >> LUT_SHIFT);
                    state    <= StWait1;
                end
                StWait1: state <= StWait2;
                StWait2: state <= StMac;
                StMac: begin
                    acc       <= acc + term;
                    increment <= increment + 24'(freq_l);
                    amp_cur   <= (amp_cur > amp_step_l) ? amp_cur - amp_step_l : '0;
                    if (h < active_l) begin
                        h     <= h + 8'd1;
                        state <= StRead;
                    end else begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    sample_out   <= sat16 + DAC_OFFSET;
                    sample_valid <= 1'b1;
                    state        <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_additive_engine.sv
// Randomised self-checking bench for additive_engine against an arithmetic frame model.
module tb_additive_engine;
    import additive_pkg::*;

    localparam int SI = 100;
    localparam int N  = 16;
    localparam int PM = 48000;

    logic               clock = 1'b0;
    logic               reset;
    logic [15:0]        frequency;
    logic [7:0]         active_harmonics;
    logic [6:0]         amp_start;
    logic [6:0]         amp_step;
    logic [10:0]        lut_addr;
    logic signed [15:0] lut_value;
    logic signed [15:0] lut_p1;
    logic [15:0]        sample_out;
    logic               sample_valid;
    logic               overrun;
    logic               clear_overrun;

    int checks = 0;
    int errors = 0;
    int cyc;
    int lut_tab [2048];
    int ph [N+1];

    additive_engine #(
        .NUM_HARMONICS  (N),
        .PHASE_MOD      (PM),
        .SAMPLE_INTERVAL(SI),
        .LUT_SHIFT      (5),
        .AMP_W          (7),
        .ACC_W          (32)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .frequency       (frequency),
        .active_harmonics(active_harmonics),
        .amp_start       (amp_start),
        .amp_step        (amp_step),
        .lut_addr        (lut_addr),
        .lut_value       (lut_value),
        .sample_out      (sample_out),
        .sample_valid    (sample_valid),
        .overrun         (overrun),
        .clear_overrun   (clear_overrun)
    );

    always #5 clock = ~clock;

    // External sine ROM with LUT_LATENCY (=2) registered stages.
    always @(posedge clock) begin
        lut_p1    <= 16'(lut_tab[lut_addr]);
        lut_value <= lut_p1;
    end

    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // ev_kind: 0 none, 1 force an early tick at offset ev_at, 2 reset at offset ev_at.
    task automatic run_frame(input int f, input int n_in, input int as, input int st,
                             input int ev_at, input int ev_kind);
        int n, acc, amp, inc, s, guard;
        int addr_e [N+1];
        guard = 0;
        while (cyc % SI != SI - 1 && guard < 2 * SI) begin
            @(negedge clock);
            guard++;
            check("idle_valid", int'(sample_valid), 0);
        end
        check("tick_sync", cyc % SI, SI - 1);
        frequency        = 16'(f);
        active_harmonics = 8'(n_in);
        amp_start        = 7'(as);
        amp_step         = 7'(st);

        n   = (n_in > N) ? N : n_in;
        acc = 0;
        for (int hh = 1; hh <= n; hh++) begin
            inc         = hh * f;
            ph[hh]      = (ph[hh] + inc) % PM;
            addr_e[hh]  = ph[hh] >> 5;
            amp         = as - (hh - 1) * st;
            if (amp < 0) amp = 0;
            if (inc >= PM / 2) amp = 0;
            acc += (lut_tab[addr_e[hh]] * amp) >>> 7;
        end
        s = (acc > 32767) ? 32767 : ((acc < -32768) ? -32768 : acc);
        s = s + 32768;

        for (int o = 1; o <= 3 + 6 * n; o++) begin
            @(negedge clock);
            if (o == 2) begin
                frequency        = 16'($urandom);
                active_harmonics = 8'($urandom);
                amp_start        = 7'($urandom);
                amp_step         = 7'($urandom);
            end
            if (ev_kind == 1 && o == ev_at) force dut.sample_timer = 7'(SI - 1);
            if (ev_kind == 1 && o == ev_at + 1) begin
                release dut.sample_timer;
                check("overrun_set", int'(overrun), 1);
            end
            if (ev_kind == 2 && o == ev_at) begin
                reset = 1'b1;
                repeat (4) begin
                    @(negedge clock);
                    check("abort_valid", int'(sample_valid), 0);
                    check("abort_sample", int'(sample_out), 32768);
                    check("abort_addr", int'(lut_addr), 0);
                end
                reset = 1'b0;
                for (int i = 0; i <= N; i++) ph[i] = 0;
                return;
            end
            if (o % 6 == 5 && (o + 1) / 6 <= n)
                check($sformatf("lut_addr_h%0d", (o + 1) / 6), int'(lut_addr),
                      addr_e[(o + 1) / 6]);
            if (o == 2 + 6 * n) check("valid_early", int'(sample_valid), 0);
            if (o == 3 + 6 * n) begin
                check("valid_pulse", int'(sample_valid), 1);
                check($sformatf("sample_f%0d_n%0d", f, n_in), int'(sample_out), s);
                if (ev_kind == 0) check("no_overrun", int'(overrun), 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int a = 0; a < 2048; a++)
            lut_tab[a] = $rtoi($floor(32767.0 * $sin(6.283185307179586 * a / 1500.0) + 0.5));
        for (int i = 0; i <= N; i++) ph[i] = 0;
        reset            = 1'b1;
        clear_overrun    = 1'b0;
        frequency        = '0;
        active_harmonics = '0;
        amp_start        = '0;
        amp_step         = '0;
        repeat (3) @(negedge clock);
        check("rst_sample", int'(sample_out), int'(DAC_OFFSET));
        check("rst_valid", int'(sample_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_addr", int'(lut_addr), 0);
        reset = 1'b0;

        repeat (4) run_frame(1000, 1, 127, 0, 0, 0);
        repeat (2) run_frame(6000, 8, 100, 5, 0, 0);
        repeat (2) run_frame(1234, 0, 127, 3, 0, 0);
        repeat (2) run_frame(500, 6, 10, 4, 0, 0);
        repeat (8) run_frame($urandom_range(0, 65535), $urandom_range(0, 20),
                             $urandom_range(0, 127), $urandom_range(0, 40), 0, 0);
        repeat (2) run_frame(3000, 16, 127, 7, 0, 0);

        run_frame(2500, 12, 90, 6, 30, 2);
        run_frame(2500, 12, 90, 6, 0, 0);

        run_frame(700, 16, 127, 7, 10, 1);
        active_harmonics = 8'd0;
        repeat (20) @(negedge clock);
        check("overrun_sticky", int'(overrun), 1);
        clear_overrun = 1'b1;
        @(negedge clock);
        clear_overrun = 1'b0;
        check("overrun_clear", int'(overrun), 0);
        w = 0;
        while (!sample_valid && w < 250) begin
            @(negedge clock);
            w++;
        end
        check("post_clear_valid", int'(sample_valid), 1);
        check("post_clear_sample", int'(sample_out), 32768);
        check("post_clear_overrun", int'(overrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
